// File: rtl/ysyx_24100029_rr_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100029_arb_pkg
// Purpose  : Shared types and helpers for the four-way round-robin arbiter:
//            FSM state encoding, requester count and rotating-priority pick.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24100029_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // First set request bit scanning ptr, ptr+1, ... (mod NUM_REQ), one-hot.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [1:0] ptr,
                                                 input logic [NUM_REQ-1:0] req);
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24100029_rr_arbiter4_mux.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100029_rr_arbiter4_mux
// Purpose  : 4-to-1 payload mux. With Is_One_Hot set the select is trusted to
//            be one-hot (or zero) and an AND-OR tree is built; otherwise a
//            lowest-index-wins priority mux is used.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100029_rr_arbiter4_mux #(
  parameter int Is_One_Hot = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic [3:0]              sel,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]   out_data
);

  generate
    if (Is_One_Hot != 0) begin : g_and_or
      // OR together every input gated by its select bit.
      always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++) begin
          out_data = out_data | (in_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[k]}});
        end
      end
    end else begin : g_priority
      // Lowest selected index wins when several select bits are set.
      always_comb begin
        out_data = '0;
        for (int k = 3; k >= 0; k--) begin
          if (sel[k]) out_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ysyx_24100029_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100029_rr_arbiter4
// Purpose  : Round-robin arbiter sharing one downstream request/response port
//            among four requesters, one transaction at a time
//            (IDLE -> REQ -> RESP). Registered one-hot grant drives the
//            payload mux and is exported for other datapath muxes.
// Options  : YSYX_24100029_ARB_TIMEOUT_EN - response watchdog that completes
//            a stalled RESP with resp_err_o after TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100029_rr_arbiter4
  import ysyx_24100029_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int RESP_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              req_valid_i,
  output logic [3:0]              req_ready_o,
  input  logic [4*DATA_WIDTH-1:0] req_payload_i,
  output logic [3:0]              resp_valid_o,
  input  logic [3:0]              resp_ready_i,
  output logic [RESP_WIDTH-1:0]   resp_payload_o,
  output logic                    resp_err_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DATA_WIDTH-1:0]   m_payload_o,
  input  logic                    m_resp_valid_i,
  output logic                    m_resp_ready_o,
  input  logic [RESP_WIDTH-1:0]   m_resp_payload_i,
  output logic [3:0]              grant_o,
  output logic                    busy_o
);

  arb_state_e state;
  logic [1:0] prio_ptr;
  logic [1:0] grant_idx;
  logic       in_req;
  logic       in_resp;
  logic       timed_out;
  logic       resp_valid_sel;
  logic       granted_ready;
  logic       resp_fire;

  assign in_req    = (state == ST_REQ);
  assign in_resp   = (state == ST_RESP);
  assign grant_idx = {grant_o[3] | grant_o[2], grant_o[3] | grant_o[1]};

  // A timed-out RESP presents a synthetic response to the granted requester.
  assign resp_valid_sel = m_resp_valid_i | timed_out;
  assign granted_ready  = |(grant_o & resp_ready_i);
  assign resp_fire      = in_resp & resp_valid_sel & granted_ready;

  // Requester and downstream handshake routing for the current grant.
  always_comb begin
    req_ready_o    = in_req  ? (grant_o & {4{m_ready_i}})      : 4'b0000;
    resp_valid_o   = in_resp ? (grant_o & {4{resp_valid_sel}}) : 4'b0000;
    m_resp_ready_o = in_resp & (granted_ready | timed_out);
    resp_payload_o = timed_out ? '0 : m_resp_payload_i;
    resp_err_o     = in_resp & timed_out;
  end

  // Arbitration FSM with registered grant, request-valid and busy outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_o   <= 4'b0000;
      prio_ptr  <= 2'd0;
      busy_o    <= 1'b0;
      m_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid_i) begin
            grant_o   <= rr_pick(prio_ptr, req_valid_i);
            state     <= ST_REQ;
            busy_o    <= 1'b1;
            m_valid_o <= 1'b1;
          end
        end
        ST_REQ: begin
          // Grant is held even if the requester drops its valid.
          if (m_ready_i) begin
            state     <= ST_RESP;
            m_valid_o <= 1'b0;
          end
        end
        ST_RESP: begin
          if (resp_fire) begin
            prio_ptr <= grant_idx + 2'd1;
            grant_o  <= 4'b0000;
            state    <= ST_IDLE;
            busy_o   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          grant_o   <= 4'b0000;
          busy_o    <= 1'b0;
          m_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_24100029_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] wd_cnt;

  assign timed_out = in_resp & (wd_cnt == TO_W'(TIMEOUT_CYCLES));

  // Watchdog: zero while in REQ so it starts RESP at 0, saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (in_req) begin
      wd_cnt <= '0;
    end else if (in_resp && !resp_fire && !timed_out) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Grant must never carry more than one bit; watchdog limit must be nonzero.
  a_grant_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(grant_o));
  a_timeout_cfg  : assert property (@(posedge clock) disable iff (reset) TIMEOUT_CYCLES > 0);

  ysyx_24100029_rr_arbiter4_mux #(
    .Is_One_Hot (1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_payload_mux (
    .sel      (grant_o),
    .in_data  (req_payload_i),
    .out_data (m_payload_o)
  );

endmodule
`default_nettype wire

// File: doc/ysyx_24100029_rr_arbiter4.md
Name: ysyx_24100029_rr_arbiter4

Overview:
- Round-robin arbiter sharing one downstream bus port (e.g. the AXI-lite style memory port) among four requesters (IFU, LSU, DMA, debug).
- Holds one transaction at a time, from request acceptance to response completion.
- Registers a one-hot grant that drives a 4-to-1 payload mux. The same grant vector is exported for other one-hot muxes in the datapath.

Parameters:
- DATA_WIDTH, 64: per-requester request payload width (address + data + control, packed by requester).
- RESP_WIDTH, 32: response payload width.
- TIMEOUT_CYCLES, 255: response watchdog limit. Only used with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  4  per-requester request valid.
- req_ready_o  out  4  per-requester request accepted.
- req_payload_i  in  4*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- resp_valid_o  out  4  per-requester response valid.
- resp_ready_i  in  4  per-requester response ready.
- resp_payload_o  out  RESP_WIDTH  broadcast response data; only valid where resp_valid_o is set.
- resp_err_o  out  1  response error flag, qualified by resp_valid_o.
- m_valid_o  out  1  downstream request valid.
- m_ready_i  in  1  downstream request ready.
- m_payload_o  out  DATA_WIDTH  muxed request payload.
- m_resp_valid_i  in  1  downstream response valid.
- m_resp_ready_o  out  1  downstream response ready.
- m_resp_payload_i  in  RESP_WIDTH  downstream response data.
- grant_o  out  4  registered one-hot grant; 4'b0000 when idle.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert): state=IDLE, grant_o=0, prio_ptr=0. All outputs deassert (m_valid_o, m_resp_ready_o, req_ready_o, resp_valid_o, resp_err_o, busy_o all 0).
- FSM has three states: IDLE, REQ, RESP.
- IDLE:
  - If any req_valid_i is set, pick the first set bit scanning prio_ptr, prio_ptr+1, ... mod 4.
  - Register that one-hot grant and go to REQ. Latency from req_valid_i to m_valid_o is 1 cycle.
- REQ:
  - m_valid_o=1 and m_payload_o = payload of the granted requester, via the one-hot mux.
  - req_ready_o[g] = m_ready_i combinationally; all other bits are 0.
  - On m_valid_o & m_ready_i, go to RESP.
  - Requesters must hold req_valid_i and payload stable until ready. If req_valid_i[g] drops in REQ, the arbiter still holds the grant (no abort).
- RESP:
  - resp_valid_o[g] = m_resp_valid_i, resp_payload_o = m_resp_payload_i, m_resp_ready_o = resp_ready_i[g].
  - On that handshake: prio_ptr = (g+1) mod 4, grant_o=0, go to IDLE.
- Minimum transaction period is 3 cycles (IDLE, REQ, RESP). The idle cycle between grants is mandatory.
- m_resp_valid_i outside RESP is ignored and m_resp_ready_o stays 0.
- New or dropped req_valid_i bits while busy do not affect the current grant. They are only considered at the next IDLE evaluation.
- grant_o is always one-hot or zero. An illegal value is a design error; simulation asserts cover it.
- Reset asserted mid-transaction returns immediately to IDLE with all outputs 0. Any downstream transaction in flight is abandoned and must be reset alongside.

Optional Feature:
- Macro: YSYX_24100029_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to RESP and increments each RESP cycle without a handshake.
  - When the count reaches TIMEOUT_CYCLES, the arbiter drives resp_valid_o[g]=1 with resp_err_o=1 and resp_payload_o=0, and asserts m_resp_ready_o=1 to drain any late response.
  - On resp_ready_i[g] it completes as a normal handshake (pointer rotates, go to IDLE).
- Undefined: no counter is built, resp_err_o is tied to 0, and RESP waits indefinitely.

Decomposition:
- Package ysyx_24100029_arb_pkg holds:
  - the state enum (IDLE/REQ/RESP, 2 bits);
  - NUM_REQ=4;
  - a function for rotating-priority one-hot pick (ptr, req -> grant).
- One sub-module: the existing one-hot 4-to-1 mux, instantiated with Is_One_Hot=1, DATA_WIDTH=DATA_WIDTH and sel=grant_o, to produce m_payload_o.
- No other sub-modules.

Test Plan:
- Single requester: req_valid_i=4'b0100 with payload 0xA5 -> grant_o=4'b0100 next cycle and m_payload_o=0xA5. With m_ready_i=1 and m_resp_valid_i=1 on the following cycle, resp_valid_o=4'b0100 and prio_ptr becomes 3.
- All four requesting continuously, zero-wait downstream -> grant order 0,1,2,3,0. Each transaction takes 3 cycles. No requester is starved.
- Backpressure: m_ready_i held 0 for 5 cycles in REQ -> m_valid_o stays 1, payload stays stable, req_ready_o=0. When m_ready_i rises, req_ready_o[g] pulses for exactly 1 cycle.
- Late request: requester 0 granted, requester 1 raises req_valid_i mid-RESP -> no grant change. After completion, the IDLE cycle grants requester 1.
- Reset mid-RESP: assert reset -> grant_o=0, busy_o=0 and m_resp_ready_o=0 immediately. After release, the first grant starts from requester 0.
- With YSYX_24100029_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no m_resp_valid_i -> after 8 RESP cycles, resp_valid_o[g]=1 and resp_err_o=1. The FSM then returns to IDLE and the pointer rotates.
